// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// The optional BRU_STATS_EN build adds handshake statistics counters to the top level.
package bru_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_e;

    localparam int unsigned LINK_OFFSET = 4;

    // Per-result decision flags, registered alongside the address fields.
    typedef struct packed {
        logic taken;
        logic illegal;
        logic mispredict;
    } bru_flags_t;

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational RV32I branch condition evaluation: funct3 + operands -> taken / illegal.
module bru_cond_eval
    import bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    funct3_e f3;
    logic    eq;
    logic    lt_s;
    logic    lt_u;

    assign f3   = funct3_e'(funct3);
    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (f3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = !eq;
            F3_BLT:  taken = lt_s;
            F3_BGE:  taken = !lt_s;
            F3_BLTU: taken = lt_u;
            F3_BGEU: taken = !lt_u;
            // 010 and 011 have no branch meaning
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolver with valid/ready handshake, latency 1, no skid buffer.
// Define BRU_STATS_EN to add saturating branch/taken/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_is_jump,
    input  logic             in_is_jalr,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
`ifdef BRU_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_mispredict
`endif
);

    logic             accept;
    logic             cond_taken;
    logic             cond_illegal;
    logic [XLEN-1:0]  jalr_sum;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  link;
    bru_flags_t       flags;

    logic             out_valid_q,  out_valid_d;
    bru_flags_t       flags_q,      flags_d;
    logic [XLEN-1:0]  target_q,     target_d;
    logic [XLEN-1:0]  link_q,       link_d;
    logic [XLEN-1:0]  redirect_q,   redirect_d;
    logic [TAG_W-1:0] tag_q,        tag_d;

    bru_cond_eval #(.XLEN(XLEN)) u_cond_eval (
        .funct3  (in_funct3),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign jalr_sum = in_rs1 + in_imm;

    always_comb begin
        link   = in_pc + XLEN'(LINK_OFFSET);
        target = in_pc + in_imm;
        if (in_is_jump && in_is_jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end
        flags.taken      = in_is_jump || cond_taken;
        flags.illegal    = !in_is_jump && cond_illegal;
        flags.mispredict = !flags.illegal &&
                           ((flags.taken != in_pred_taken) ||
                            (flags.taken && (in_pred_target != target)));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        flags_d     = flags_q;
        target_d    = target_q;
        link_d      = link_q;
        redirect_d  = redirect_q;
        tag_d       = tag_q;
        // flush wins over both a pending output handshake and a new input
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            flags_d     = flags;
            target_d    = target;
            link_d      = link;
            redirect_d  = flags.taken ? target : link;
            tag_d       = in_tag;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            flags_q     <= '0;
            target_q    <= '0;
            link_q      <= '0;
            redirect_q  <= '0;
            tag_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
            target_q    <= target_d;
            link_q      <= link_d;
            redirect_q  <= redirect_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_taken       = flags_q.taken;
    assign out_illegal     = flags_q.illegal;
    assign out_mispredict  = flags_q.mispredict;
    assign out_target      = target_q;
    assign out_link        = link_q;
    assign out_redirect_pc = redirect_q;
    assign out_tag         = tag_q;

`ifdef BRU_STATS_EN
    logic                 stat_fire;
    logic [2:0]           stat_inc;
    logic [3*CNT_W-1:0]   stat_vec;

    // A flushed cycle is not a completed handshake, so it is not counted.
    assign stat_fire = out_valid_q && out_ready && !flush;
    assign stat_inc  = {flags_q.mispredict, flags_q.taken, !flags_q.illegal} & {3{stat_fire}};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (stat_clr) begin
                    cnt_d = '0;
                end else if (stat_inc[gi] && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stat_vec[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate

    assign stat_branches   = stat_vec[0*CNT_W +: CNT_W];
    assign stat_taken      = stat_vec[1*CNT_W +: CNT_W];
    assign stat_mispredict = stat_vec[2*CNT_W +: CNT_W];
`else
    // CNT_W only sizes the statistics counters, which this build omits.
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed vectors, randomized traffic against
// a behavioural model, backpressure/flush/reset scenarios and (with BRU_STATS_EN) counters.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
`ifdef BRU_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 32;
`endif

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready;
    logic [2:0]       in_funct3;
    logic             in_is_jump, in_is_jalr;
    logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
    logic             in_pred_taken;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, out_taken, out_mispredict, out_illegal;
    logic [XLEN-1:0]  out_target, out_link, out_redirect_pc;
    logic [TAG_W-1:0] out_tag;
`ifdef BRU_STATS_EN
    logic             stat_clr;
    logic [CNT_W-1:0] stat_branches, stat_taken, stat_mispredict;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        taken;
        logic        illegal;
        logic        mispredict;
        logic [31:0] target;
        logic [31:0] link;
        logic [31:0] redirect;
        logic [3:0]  tag;
    } exp_t;

    branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_is_jump(in_is_jump), .in_is_jalr(in_is_jalr),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_link(out_link), .out_redirect_pc(out_redirect_pc),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal), .out_tag(out_tag)
`ifdef BRU_STATS_EN
        , .stat_clr(stat_clr), .stat_branches(stat_branches),
        .stat_taken(stat_taken), .stat_mispredict(stat_mispredict)
`endif
    );

    always #5 clk = ~clk;

    // Reference: RV32I branch semantics evaluated directly from the architectural rules.
    function automatic exp_t ref_model(input logic [2:0] f3, input logic jmp, input logic jalr,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic pt, input logic [31:0] ptgt,
                                       input logic [3:0] tag);
        exp_t e;
        bit   cond [8];
        cond[0] = (rs1 == rs2);
        cond[1] = (rs1 != rs2);
        cond[2] = 1'b0;
        cond[3] = 1'b0;
        cond[4] = ($signed(rs1) < $signed(rs2));
        cond[5] = !($signed(rs1) < $signed(rs2));
        cond[6] = (rs1 < rs2);
        cond[7] = !(rs1 < rs2);
        e.illegal    = !jmp && (f3 == 3'd2 || f3 == 3'd3);
        e.taken      = jmp ? 1'b1 : cond[f3];
        e.target     = (jmp && jalr) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        e.link       = pc + 32'd4;
        e.redirect   = e.taken ? e.target : e.link;
        e.mispredict = !e.illegal && ((e.taken != pt) || (e.taken && ptgt != e.target));
        e.tag        = tag;
        return e;
    endfunction

    task automatic drive(input logic [2:0] f3, input logic jmp, input logic jalr,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt, input logic [3:0] tag);
        in_valid = 1'b1; in_funct3 = f3; in_is_jump = jmp; in_is_jalr = jalr;
        in_rs1 = rs1; in_rs2 = rs2; in_pc = pc; in_imm = imm;
        in_pred_taken = pt; in_pred_target = ptgt; in_tag = tag;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || {out_taken, out_illegal, out_mispredict, out_target,
                                   out_link, out_redirect_pc, out_tag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b taken=%b target=%h link=%h redirect=%h tag=%h, required all zero",
                     out_valid, out_taken, out_target, out_link, out_redirect_pc, out_tag);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        jmp, jalr;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_taken, e_ill, e_mis;
        logic [31:0] e_target, e_redir;
    } dir_t;

    task automatic test_directed();
        dir_t tbl [11];
        tbl[0]  = '{3'b000, 1'b0, 1'b0, 32'd10, 32'd10, 32'h100, 32'h20, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'h120, 32'h120};
        tbl[1]  = '{3'b100, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd3, 32'h200, 32'h40, 1'b1, 32'h240,
                    1'b1, 1'b0, 1'b0, 32'h240, 32'h240};
        tbl[2]  = '{3'b110, 1'b0, 1'b0, 32'hFFFF_FFFB, 32'd3, 32'h200, 32'h40, 1'b1, 32'h240,
                    1'b0, 1'b0, 1'b1, 32'h240, 32'h204};
        tbl[3]  = '{3'b000, 1'b1, 1'b1, 32'h1001, 32'h0, 32'h300, 32'h4, 1'b1, 32'h1004,
                    1'b1, 1'b0, 1'b0, 32'h1004, 32'h1004};
        tbl[4]  = '{3'b010, 1'b0, 1'b0, 32'd5, 32'd5, 32'h400, 32'h8, 1'b1, 32'h408,
                    1'b0, 1'b1, 1'b0, 32'h408, 32'h404};
        tbl[5]  = '{3'b100, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h500, 32'hFFFF_FFF8,
                    1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4F8, 32'h4F8};
        tbl[6]  = '{3'b111, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h600, 32'h10, 1'b1,
                    32'h610, 1'b1, 1'b0, 1'b0, 32'h610, 32'h610};
        tbl[7]  = '{3'b100, 1'b0, 1'b0, 32'd7, 32'd7, 32'h700, 32'h10, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h710, 32'h704};
        tbl[8]  = '{3'b101, 1'b0, 1'b0, 32'd7, 32'd7, 32'h700, 32'h10, 1'b1, 32'h0,
                    1'b1, 1'b0, 1'b1, 32'h710, 32'h710};
        tbl[9]  = '{3'b011, 1'b1, 1'b0, 32'd1, 32'd2, 32'h800, 32'h100, 1'b1, 32'h900,
                    1'b1, 1'b0, 1'b0, 32'h900, 32'h900};
        tbl[10] = '{3'b001, 1'b0, 1'b0, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10,
                    1'b1, 1'b0, 1'b0, 32'h10, 32'h10};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].f3, tbl[i].jmp, tbl[i].jalr, tbl[i].rs1, tbl[i].rs2, tbl[i].pc,
                  tbl[i].imm, tbl[i].pt, tbl[i].ptgt, 4'(i));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if ({out_valid, out_taken, out_illegal, out_mispredict, out_target, out_link,
                 out_redirect_pc, out_tag} !==
                {1'b1, tbl[i].e_taken, tbl[i].e_ill, tbl[i].e_mis, tbl[i].e_target,
                 tbl[i].pc + 32'd4, tbl[i].e_redir, 4'(i)}) begin
                errors++;
                $display("FAIL directed_%0d: got v=%b t=%b i=%b m=%b tgt=%h lnk=%h rd=%h tag=%h, required v=1 t=%b i=%b m=%b tgt=%h lnk=%h rd=%h tag=%h",
                         i, out_valid, out_taken, out_illegal, out_mispredict, out_target,
                         out_link, out_redirect_pc, out_tag, tbl[i].e_taken, tbl[i].e_ill,
                         tbl[i].e_mis, tbl[i].e_target, tbl[i].pc + 32'd4, tbl[i].e_redir, 4'(i));
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL directed_drain: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_random();
        exp_t        held, nxt;
        logic        mv;
        logic        exp_ready;
        logic [31:0] rs1, rs2, pc, imm;
        mv = 1'b0;
        held = ref_model(3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 4'd0);
        for (int cyc = 0; cyc < 400; cyc++) begin
            rs1 = pick_operand();
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : pick_operand();
            pc  = $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            drive(3'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), rs1, rs2, pc, imm,
                  1'($urandom), 32'h0, 4'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            nxt = ref_model(in_funct3, in_is_jump, in_is_jalr, rs1, rs2, pc, imm,
                            in_pred_taken, 32'h0, in_tag);
            // Half the time offer the correct target so target-match paths get exercised.
            in_pred_target = ($urandom_range(0, 1) == 0) ? nxt.target : $urandom;
            nxt = ref_model(in_funct3, in_is_jump, in_is_jalr, rs1, rs2, pc, imm,
                            in_pred_taken, in_pred_target, in_tag);
            #1;
            exp_ready = !flush && (!mv || out_ready);
            checks++;
            if (in_ready !== exp_ready || out_valid !== mv) begin
                errors++;
                $display("FAIL random_hs cycle %0d: in_ready=%b out_valid=%b, required %b %b",
                         cyc, in_ready, out_valid, exp_ready, mv);
            end
            if (mv) begin
                checks++;
                if ({out_taken, out_illegal, out_mispredict, out_target, out_link,
                     out_redirect_pc, out_tag} !==
                    {held.taken, held.illegal, held.mispredict, held.target, held.link,
                     held.redirect, held.tag}) begin
                    errors++;
                    $display("FAIL random_data cycle %0d: got t=%b i=%b m=%b tgt=%h lnk=%h rd=%h tag=%h, required t=%b i=%b m=%b tgt=%h lnk=%h rd=%h tag=%h",
                             cyc, out_taken, out_illegal, out_mispredict, out_target, out_link,
                             out_redirect_pc, out_tag, held.taken, held.illegal,
                             held.mispredict, held.target, held.link, held.redirect, held.tag);
                end
            end
            if (flush) begin
                mv = 1'b0;
            end else if (in_valid && exp_ready) begin
                mv = 1'b1;
                held = nxt;
            end else if (mv && out_ready) begin
                mv = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        exp_t a, b, c;
        a = ref_model(3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'h1000, 32'h40, 1'b1, 32'h1040, 4'd1);
        b = ref_model(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'h2000, 32'h8, 1'b1, 32'h0, 4'd2);
        c = ref_model(3'b000, 1'b1, 1'b0, 32'd0, 32'd0, 32'h3000, 32'hFFFF_FF00, 1'b0, 32'h0, 4'd3);
        out_ready = 1'b1;
        drive(3'b000, 1'b0, 1'b0, 32'd9, 32'd9, 32'h1000, 32'h40, 1'b1, 32'h1040, 4'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'h2000, 32'h8, 1'b1, 32'h0, 4'd2);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {out_taken, out_mispredict, out_target, out_redirect_pc, out_tag} !==
                {a.taken, a.mispredict, a.target, a.redirect, a.tag}) begin
                errors++;
                $display("FAIL hold_%0d: in_ready=%b v=%b t=%b m=%b tgt=%h rd=%h tag=%h, required 0 1 %b %b %h %h %h",
                         i, in_ready, out_valid, out_taken, out_mispredict, out_target,
                         out_redirect_pc, out_tag, a.taken, a.mispredict, a.target,
                         a.redirect, a.tag);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        drive(3'b000, 1'b1, 1'b0, 32'd0, 32'd0, 32'h3000, 32'hFFFF_FF00, 1'b0, 32'h0, 4'd3);
        checks++;
        if ({out_valid, out_taken, out_mispredict, out_target, out_redirect_pc, out_tag} !==
            {1'b1, b.taken, b.mispredict, b.target, b.redirect, b.tag}) begin
            errors++;
            $display("FAIL b2b_second: v=%b t=%b m=%b tgt=%h rd=%h tag=%h, required 1 %b %b %h %h %h",
                     out_valid, out_taken, out_mispredict, out_target, out_redirect_pc, out_tag,
                     b.taken, b.mispredict, b.target, b.redirect, b.tag);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_taken, out_mispredict, out_target, out_link, out_tag} !==
            {1'b1, c.taken, c.mispredict, c.target, c.link, c.tag}) begin
            errors++;
            $display("FAIL b2b_third: v=%b t=%b m=%b tgt=%h lnk=%h tag=%h, required 1 %b %b %h %h %h",
                     out_valid, out_taken, out_mispredict, out_target, out_link, out_tag,
                     c.taken, c.mispredict, c.target, c.link, c.tag);
        end
        // Now hold C and flush with a new µop offered: both must be discarded.
        out_ready = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold: out_valid=%b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_accept: out_valid=%b, required 0", out_valid);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_hold();
        out_ready = 1'b0;
        drive(3'b001, 1'b0, 1'b0, 32'd1, 32'd2, 32'h4000, 32'h4, 1'b1, 32'h4004, 4'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd7) begin
            errors++;
            $display("FAIL rst_hold_setup: v=%b tag=%h, required 1 7", out_valid, out_tag);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || {out_taken, out_target, out_link, out_redirect_pc,
                                   out_tag} !== '0) begin
            errors++;
            $display("FAIL rst_mid_hold: v=%b t=%b tgt=%h lnk=%h rd=%h tag=%h, required all zero",
                     out_valid, out_taken, out_target, out_link, out_redirect_pc, out_tag);
        end
        out_ready = 1'b1;
    endtask

`ifdef BRU_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        checks++;
        if ({stat_branches, stat_taken, stat_mispredict} !== '0) begin
            errors++;
            $display("FAIL stats_clear: %0d %0d %0d, required 0 0 0",
                     stat_branches, stat_taken, stat_mispredict);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(3'b000, 1'b0, 1'b0, 32'd4, 32'd4, 32'h100, 32'h8, 1'b0, 32'h0, 4'(i));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (stat_branches !== 2'd3 || stat_taken !== 2'd3 || stat_mispredict !== 2'd3) begin
            errors++;
            $display("FAIL stats_saturate: %0d %0d %0d, required 3 3 3",
                     stat_branches, stat_taken, stat_mispredict);
        end
        drive(3'b000, 1'b0, 1'b0, 32'd4, 32'd4, 32'h100, 32'h8, 1'b0, 32'h0, 4'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        checks++;
        if ({stat_branches, stat_taken, stat_mispredict} !== '0) begin
            errors++;
            $display("FAIL stats_clr_wins: %0d %0d %0d, required 0 0 0",
                     stat_branches, stat_taken, stat_mispredict);
        end
        drive(3'b001, 1'b0, 1'b0, 32'd4, 32'd4, 32'h100, 32'h8, 1'b0, 32'h0, 4'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (stat_branches !== 2'd1 || stat_taken !== 2'd0 || stat_mispredict !== 2'd0) begin
            errors++;
            $display("FAIL stats_not_taken: %0d %0d %0d, required 1 0 0",
                     stat_branches, stat_taken, stat_mispredict);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_funct3 = '0; in_is_jump = 1'b0; in_is_jalr = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_pc = '0; in_imm = '0;
        in_pred_taken = 1'b0; in_pred_target = '0; in_tag = '0;
`ifdef BRU_STATS_EN
        stat_clr = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_hold();
`ifdef BRU_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
